// File: rtl/bram_pkg.sv
// Shared constants and types for the block RAM port front-end.
package bram_pkg;

  localparam int unsigned DEF_NUM_COL    = 4;
  localparam int unsigned DEF_COL_WIDTH  = 8;
  localparam int unsigned DEF_ADDR_WIDTH = 10;

  localparam int unsigned RSP_FIFO_DEPTH = 3;
  localparam int unsigned RSP_CNT_W      = $clog2(RSP_FIFO_DEPTH + 1);

  typedef enum logic {
    INIT,
    RUN
  } state_t;

endpackage

// File: rtl/bram_port_ctrl_if.sv
// Request/response handshake bundle between a client and bram_port_ctrl.
interface bram_port_ctrl_if
  import bram_pkg::*;
#(
  parameter int unsigned NUM_COL    = DEF_NUM_COL,
  parameter int unsigned COL_WIDTH  = DEF_COL_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = NUM_COL * COL_WIDTH
);

  logic                  req_valid;
  logic                  req_ready;
  logic [NUM_COL-1:0]    req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_wr;

  // Client side: issues requests, consumes responses.
  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_wr
  );

  // Controller side.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_wr
  );

endinterface

// File: rtl/bram_rsp_fifo.sv
// Small response FIFO with a registered head entry; caller guarantees no overflow.
module bram_rsp_fifo
  import bram_pkg::*;
#(
  parameter int unsigned WIDTH = 33
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_data,
  input  logic                 pop,
  output logic [WIDTH-1:0]     head,
  output logic                 valid,
  output logic [RSP_CNT_W-1:0] count
);

  logic [WIDTH-1:0]     mem_q [RSP_FIFO_DEPTH];
  logic [WIDTH-1:0]     mem_d [RSP_FIFO_DEPTH];
  logic [RSP_CNT_W-1:0] count_q, count_d;
  logic [RSP_CNT_W-1:0] wr_idx;
  logic                 do_pop;

  // Shift-on-pop storage so entry 0 is always the registered head.
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    do_pop  = pop && (count_q != '0);
    wr_idx  = count_q;
    if (do_pop) begin
      for (int unsigned i = 0; i < RSP_FIFO_DEPTH - 1; i++) begin
        mem_d[i] = mem_q[i+1];
      end
      mem_d[RSP_FIFO_DEPTH-1] = '0;
      wr_idx = count_q - 1'b1;
    end
    if (push && (wr_idx < RSP_CNT_W'(RSP_FIFO_DEPTH))) begin
      mem_d[wr_idx] = push_data;
    end
    count_d = count_q + RSP_CNT_W'(push) - RSP_CNT_W'(do_pop);
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < RSP_FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
    end
  end

  assign head  = mem_q[0];
  assign valid = (count_q != '0);
  assign count = count_q;

endmodule

// File: rtl/bram_port_ctrl.sv
// Request/response front-end for one byte-write, read-first block RAM port.
module bram_port_ctrl
  import bram_pkg::*;
#(
  parameter int unsigned NUM_COL    = DEF_NUM_COL,
  parameter int unsigned COL_WIDTH  = DEF_COL_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = NUM_COL * COL_WIDTH,
  parameter bit          INIT_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  bram_port_ctrl_if.slave       bus,
  output logic                  ram_en,
  output logic [NUM_COL-1:0]    ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  init_done
);

  localparam int unsigned CW = RSP_CNT_W + 1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  inflight_q, wr_q;
  logic                  run, accept;
  logic [CW-1:0]         credit_used;

  logic [DATA_WIDTH:0]   fifo_head;
  logic                  fifo_valid;
  logic [RSP_CNT_W-1:0]  fifo_count;

  // Outputs are held quiet while rst is high so reset values show immediately.
  assign run         = (state_q == RUN) && !rst;
  assign credit_used = CW'(fifo_count) + CW'(inflight_q);
  assign bus.req_ready = run && (credit_used < CW'(RSP_FIFO_DEPTH));
  assign accept      = bus.req_valid && bus.req_ready;
  assign init_done   = run;

  // Next-state logic: INIT walks cnt across the array, then hands over to RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (!INIT_EN || (cnt_q == '1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: state_d = INIT;
    endcase
  end

  // RAM port drive: zero-fill sweep in INIT, request passthrough on accept in RUN.
  always_comb begin
    ram_en   = 1'b0;
    ram_we   = '0;
    ram_addr = '0;
    ram_din  = '0;
    if (!rst) begin
      if ((state_q == INIT) && INIT_EN) begin
        ram_en   = 1'b1;
        ram_we   = '1;
        ram_addr = cnt_q;
      end else if (accept) begin
        ram_en   = 1'b1;
        ram_we   = bus.req_we;
        ram_addr = bus.req_addr;
        ram_din  = bus.req_wdata;
      end
    end
  end

  // State, sweep counter and the one-cycle in-flight marker for RAM capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT_EN ? INIT : RUN;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      wr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inflight_q <= accept;
      wr_q       <= accept && (|bus.req_we);
    end
  end

  bram_rsp_fifo #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data ({wr_q, ram_dout}),
    .pop       (fifo_valid && bus.rsp_ready),
    .head      (fifo_head),
    .valid     (fifo_valid),
    .count     (fifo_count)
  );

  assign bus.rsp_valid = fifo_valid;
  assign bus.rsp_wr    = fifo_head[DATA_WIDTH];
  assign bus.rsp_data  = fifo_head[DATA_WIDTH-1:0];

endmodule
